// File: rtl/four_bit_spi_pkg.sv
// Shared constants and state encoding for the four-bit SPI link.
// Used by both the transmitter and the receiver.
package four_bit_spi_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int MAX_PACKS  = 16;
  localparam int NIBBLE_W   = 4;
  localparam int PACK_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_IDLE = 2'd2,
    RECEIVE   = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-bit pin synchroniser; all bits share one
// chain so their relative skew is preserved.
module spi_input_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '1;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/four_bit_spi_receiver.sv
// Quad-SPI responder: captures sdio nibbles on
// oversampled rising sclk and delivers 64-bit frames.
module four_bit_spi_receiver
  import four_bit_spi_pkg::spi_state_t,
         four_bit_spi_pkg::NIBBLE_W,
         four_bit_spi_pkg::PACK_CNT_W,
         four_bit_spi_pkg::IDLE,
         four_bit_spi_pkg::WAIT_IDLE,
         four_bit_spi_pkg::RECEIVE;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PACKS   = 16,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic                  sclk,
  input  logic [3:0]            sdio,
  input  logic                  ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [PACK_CNT_W-1:0] packs_received,
  output logic                  overflow,
  output logic                  valid,
  output logic                  busy,
  output logic                  lost
);

  localparam logic [PACK_CNT_W-1:0] MAX_CNT =
    PACK_CNT_W'(MAX_PACKS);

  logic [5:0]          sync_q;
  logic                sync_cs;
  logic                sync_sclk;
  logic [3:0]          sync_sdio;
  logic                sclk_prev;
  logic                sclk_rise;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                primed;

  spi_state_t          state_q;
  spi_state_t          state_d;
  logic                frame_start;
  logic                capture;
  logic                frame_end;

  logic [DATA_WIDTH-1:0] word_q;
  logic [PACK_CNT_W-1:0] cnt_q;
  logic                  flag_q;
  logic                  done_q;

  spi_input_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (6)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       ({sdio, sclk, cs}),
    .q       (sync_q)
  );

  assign sync_cs   = sync_q[0];
  assign sync_sclk = sync_q[1];
  assign sync_sdio = sync_q[5:2];
  assign sclk_rise = sync_sclk & ~sclk_prev;
  assign primed    = prime_q[SYNC_STAGES-1];

  // The chain resets to idle levels, so sync_cs only
  // reflects the pin once every stage has refilled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prime_q   <= '0;
      sclk_prev <= 1'b1;
    end else begin
      prime_q   <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sync_sclk;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_IDLE: if (primed && sync_cs) state_d = IDLE;
      IDLE:      if (!sync_cs)          state_d = RECEIVE;
      RECEIVE:   if (sync_cs)           state_d = IDLE;
      default:                          state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    capture     = 1'b0;
    frame_end   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        frame_start = !sync_cs;
      end
      (state_q == RECEIVE): begin
        capture   = !sync_cs && sclk_rise;
        frame_end = sync_cs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      cnt_q  <= '0;
      flag_q <= 1'b0;
      busy   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= frame_end && (cnt_q != '0);
      if (frame_start) begin
        word_q <= '0;
        cnt_q  <= '0;
        flag_q <= 1'b0;
        busy   <= 1'b1;
      end
      if (frame_end) begin
        busy <= 1'b0;
      end
      if (capture) begin
        if (cnt_q < MAX_CNT) begin
          for (int k = 0; k < MAX_PACKS; k++) begin
            if (cnt_q == PACK_CNT_W'(k)) begin
              word_q[k*NIBBLE_W +: NIBBLE_W] <= sync_sdio;
            end
          end
          cnt_q <= cnt_q + 1'b1;
        end else begin
          flag_q <= 1'b1;
        end
      end
    end
  end

  // A completion wins over a same-cycle ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out       <= '0;
      packs_received <= '0;
      overflow       <= 1'b0;
      valid          <= 1'b0;
      lost           <= 1'b0;
    end else begin
      lost <= 1'b0;
      if (done_q) begin
        if (!valid || ack) begin
          data_out       <= word_q;
          packs_received <= cnt_q;
          overflow       <= flag_q;
          valid          <= 1'b1;
        end else begin
          lost <= 1'b1;
        end
      end else if (ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_spi_receiver.sv
// Randomised bench for four_bit_spi_receiver with a
// transaction-level model and directed pins.
module tb_four_bit_spi_receiver;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cs;
  logic        sclk;
  logic [3:0]  sdio;
  logic        ack;
  logic [63:0] data_out;
  logic [4:0]  packs_received;
  logic        overflow;
  logic        valid;
  logic        busy;
  logic        lost;

  four_bit_spi_receiver dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cs             (cs),
    .sclk           (sclk),
    .sdio           (sdio),
    .ack            (ack),
    .data_out       (data_out),
    .packs_received (packs_received),
    .overflow       (overflow),
    .valid          (valid),
    .busy           (busy),
    .lost           (lost)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    int          kind;
    logic [63:0] data;
    int          packs;
    bit          ovf;
  } ev_t;

  ev_t         evq[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          ack_at = -10;
  bit          auto_ack = 0;
  bit          ack_on_done = 0;
  int          lost_cnt = 0;
  int          busy_cnt = 0;
  logic [3:0]  fnib [24];

  bit          m_valid = 0;
  bit          m_lost = 0;
  bit          m_busy = 0;
  bit          m_ovf = 0;
  logic [63:0] m_data = '0;
  int          m_packs = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Transaction model: events fire on known cycles.
  initial forever begin
    @(posedge clock);
    cyc++;
    if (!reset_n) begin
      evq.delete();
      m_valid = 0;
      m_lost  = 0;
      m_busy  = 0;
      m_ovf   = 0;
      m_data  = '0;
      m_packs = 0;
    end else begin
      bit fire;
      ev_t f;
      fire = 0;
      f = '{0, 0, '0, 0, 0};
      while (evq.size() > 0 && evq[0].due == cyc) begin
        ev_t e;
        e = evq.pop_front();
        if (e.kind == 0) m_busy = 1;
        else if (e.kind == 1) m_busy = 0;
        else if (e.packs > 0) begin
          fire = 1;
          f = e;
        end
      end
      m_lost = 0;
      if (fire) begin
        if (!m_valid || ack) begin
          m_valid = 1;
          m_data  = f.data;
          m_packs = f.packs;
          m_ovf   = f.ovf;
        end else begin
          m_lost = 1;
        end
      end else if (ack) begin
        m_valid = 0;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset_n) begin
      chk("valid", 64'(valid), 64'(m_valid));
      chk("lost", 64'(lost), 64'(m_lost));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("data_out", data_out, m_data);
      chk("packs", 64'(packs_received), 64'(m_packs));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (lost) lost_cnt++;
      if (busy) busy_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (cyc == ack_at) ack = 1'b1;
    else if (auto_ack) ack = ($urandom_range(0, 3) == 0);
    else ack = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    repeat (2) tick();
  endtask

  task automatic send_nibble(input logic [3:0] nib);
    sclk = 1'b0;
    sdio = nib;
    repeat ($urandom_range(2, 3)) tick();
    sclk = 1'b1;
    repeat ($urandom_range(2, 3)) tick();
  endtask

  task automatic send_frame(input int n, input bit track);
    logic [63:0] d;
    int p;
    cs = 1'b0;
    if (track) evq.push_back('{cyc + 3, 0, '0, 0, 0});
    repeat (4) tick();
    for (int k = 0; k < n; k++) send_nibble(fnib[k]);
    cs = 1'b1;
    if (track) begin
      d = '0;
      for (int k = 0; k < n && k < 16; k++) d[4*k +: 4] = fnib[k];
      p = (n > 16) ? 16 : n;
      evq.push_back('{cyc + 3, 1, '0, 0, 0});
      evq.push_back('{cyc + 4, 2, d, p, n > 16});
      if (ack_on_done) ack_at = cyc + 3;
      ack_on_done = 0;
    end
    repeat (6) tick();
  endtask

  initial begin
    logic [63:0] w;
    reset_n = 1'b0;
    cs      = 1'b1;
    sclk    = 1'b1;
    sdio    = 4'h0;
    ack     = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_packs", 64'(packs_received), 64'd0);
    reset_n = 1'b1;
    repeat (4) tick();

    w = 64'h0123_4567_89AB_CDEF;
    for (int k = 0; k < 16; k++) fnib[k] = w[4*k +: 4];
    send_frame(16, 1);
    repeat (8) tick();
    chk("t1_data", data_out, 64'h0123_4567_89AB_CDEF);
    chk("t1_packs", 64'(packs_received), 64'd16);
    chk("t1_ovf", 64'(overflow), 64'd0);
    chk("t1_valid", 64'(valid), 64'd1);
    do_ack();
    chk("t1_valid_clr", 64'(valid), 64'd0);

    fnib[0] = 4'hA; fnib[1] = 4'h5; fnib[2] = 4'hF;
    send_frame(3, 1);
    chk("t2_data", data_out, 64'h0000_0000_0000_0F5A);
    chk("t2_packs", 64'(packs_received), 64'd3);
    do_ack();

    for (int k = 0; k < 16; k++) fnib[k] = 4'h1;
    fnib[16] = 4'h7; fnib[17] = 4'h7;
    send_frame(18, 1);
    chk("t3_data", data_out, 64'h1111_1111_1111_1111);
    chk("t3_packs", 64'(packs_received), 64'd16);
    chk("t3_ovf", 64'(overflow), 64'd1);
    do_ack();

    lost_cnt = 0;
    fnib[0] = 4'h1; fnib[1] = 4'h2;
    send_frame(2, 1);
    fnib[0] = 4'h3; fnib[1] = 4'h4;
    send_frame(2, 1);
    chk("t4_hold", data_out, 64'h21);
    chk("t4_lost", 64'(lost_cnt), 64'd1);
    fnib[0] = 4'h5; fnib[1] = 4'h6; fnib[2] = 4'h7;
    ack_on_done = 1;
    send_frame(3, 1);
    chk("t4_f3_data", data_out, 64'h765);
    chk("t4_f3_valid", 64'(valid), 64'd1);
    chk("t4_f3_lost", 64'(lost_cnt), 64'd1);
    do_ack();

    busy_cnt = 0;
    lost_cnt = 0;
    send_frame(0, 1);
    chk("t6_busy_cycles", 64'(busy_cnt), 64'd4);
    chk("t6_valid", 64'(valid), 64'd0);
    chk("t6_lost", 64'(lost_cnt), 64'd0);

    cs = 1'b0;
    evq.push_back('{cyc + 3, 0, '0, 0, 0});
    repeat (4) tick();
    for (int k = 0; k < 5; k++) send_nibble(4'($urandom));
    reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_data", data_out, 64'd0);
    for (int k = 0; k < 2; k++) send_nibble(4'($urandom));
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) send_nibble(4'($urandom));
    chk("t5_no_busy", 64'(busy), 64'd0);
    cs = 1'b1;
    repeat (6) tick();
    chk("t5_no_valid", 64'(valid), 64'd0);
    for (int k = 0; k < 4; k++) fnib[k] = 4'($urandom);
    send_frame(4, 1);
    chk("t5_packs", 64'(packs_received), 64'd4);
    chk("t5_valid", 64'(valid), 64'd1);
    do_ack();

    auto_ack = 1;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(0, 20);
      for (int k = 0; k < n; k++) fnib[k] = 4'($urandom);
      send_frame(n, 1);
      repeat ($urandom_range(0, 3)) tick();
    end
    auto_ack = 0;
    do_ack();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
